// File: rtl/bricks_layer.sv
// bricks_layer: Reinforced Concrete Bricks layer (x1^5, x2*(x1^2+A1*x1+B1), x3*(x2^2+A2*x2+B2)) mod p
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only while idle
//   inState               {x1, x2, x3}, each element canonical (< p)
//   out_valid / out_ready output handshake; outState holds until accepted
//   outState              {y1, y2, y3}, canonical, driven straight from registers
//
// Build option: define BRICKS_DUAL_MUL_EN for two field multipliers and a
// 4-step schedule; otherwise a single multiplier runs an 8-step schedule.
// Results are identical in both builds.
module bricks_layer #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                STATE_SIZE    = 3,
    parameter logic [N_BITS-1:0] ALPHA1        = N_BITS'(1),
    parameter logic [N_BITS-1:0] BETA1         = N_BITS'(3),
    parameter logic [N_BITS-1:0] ALPHA2        = N_BITS'(2),
    parameter logic [N_BITS-1:0] BETA2         = N_BITS'(4)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_BITS*STATE_SIZE-1:0]   inState,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_BITS*STATE_SIZE-1:0]   outState
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state;
    logic [2:0]        step;
    logic [N_BITS-1:0] x1, x2, x3, s1, s2, s3, p1, p2, y1, y2, y3;
    logic [N_BITS-1:0] q1, q2;
    // Full-width product reduced in one combinational pass; registered every step.
    function automatic logic [N_BITS-1:0] mul_mod(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        return N_BITS'(({{N_BITS{1'b0}}, a} * {{N_BITS{1'b0}}, b}) % {{N_BITS{1'b0}}, PRIME_MODULUS});
    endfunction
    // Both operands canonical, so one conditional subtract suffices.
    function automatic logic [N_BITS-1:0] add_mod(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
        logic [N_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, PRIME_MODULUS}) ? N_BITS'(s - {1'b0, PRIME_MODULUS}) : N_BITS'(s);
    endfunction
    assign q1 = add_mod(add_mod(s1, p1), BETA1);
    assign q2 = add_mod(add_mod(s3, p2), BETA2);
    assign outState = {y1, y2, y3};
`ifdef BRICKS_DUAL_MUL_EN
    localparam logic [2:0] LAST = 3'd3;
    logic [N_BITS-1:0] a0, b0, a1, b1, m0, m1;
    always_comb begin
        a0 = x1;
        b0 = x1;
        a1 = x2;
        b1 = x2;
        case (step)
            3'd1: begin a0 = s1; b0 = s1; a1 = ALPHA1; b1 = x1; end
            3'd2: begin a0 = s2; b0 = x1; a1 = ALPHA2; b1 = x2; end
            3'd3: begin a0 = x2; b0 = q1; a1 = x3;     b1 = q2; end
            default: ;
        endcase
    end
    assign m0 = mul_mod(a0, b0);
    assign m1 = mul_mod(a1, b1);
`else
    localparam logic [2:0] LAST = 3'd7;
    logic [N_BITS-1:0] a0, b0, m0;
    always_comb begin
        a0 = x1;
        b0 = x1;
        case (step)
            3'd1: begin a0 = s1;     b0 = s1; end
            3'd2: begin a0 = s2;     b0 = x1; end
            3'd3: begin a0 = ALPHA1; b0 = x1; end
            3'd4: begin a0 = x2;     b0 = q1; end
            3'd5: begin a0 = x2;     b0 = x2; end
            3'd6: begin a0 = ALPHA2; b0 = x2; end
            3'd7: begin a0 = x3;     b0 = q2; end
            default: ;
        endcase
    end
    assign m0 = mul_mod(a0, b0);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x1 <= '0; x2 <= '0; x3 <= '0;
            s1 <= '0; s2 <= '0; s3 <= '0;
            p1 <= '0; p2 <= '0;
            y1 <= '0; y2 <= '0; y3 <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x1       <= inState[2*N_BITS +: N_BITS];
                    x2       <= inState[N_BITS +: N_BITS];
                    x3       <= inState[0 +: N_BITS];
                    step     <= '0;
                    in_ready <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: begin
`ifdef BRICKS_DUAL_MUL_EN
                    case (step)
                        3'd0: begin s1 <= m0; s3 <= m1; end
                        3'd1: begin s2 <= m0; p1 <= m1; end
                        3'd2: begin y1 <= m0; p2 <= m1; end
                        3'd3: begin y2 <= m0; y3 <= m1; end
                        default: ;
                    endcase
`else
                    case (step)
                        3'd0: s1 <= m0;
                        3'd1: s2 <= m0;
                        3'd2: y1 <= m0;
                        3'd3: p1 <= m0;
                        3'd4: y2 <= m0;
                        3'd5: s3 <= m0;
                        3'd6: p2 <= m0;
                        3'd7: y3 <= m0;
                        default: ;
                    endcase
`endif
                    step <= step + 3'd1;
                    if (step == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
